// File: rtl/slapstik_pkg.sv
// Shared constants and state encoding for the slapstik ROM fetch path.
// The one-word ROM cache is built only when SLAPSTIK_ROM_CACHE_EN is defined.
package slapstik_pkg;

  localparam logic [15:0] BANK_BASE  = 16'h4000;
  localparam logic [15:0] FIXED_BASE = 16'h8000;
  localparam logic [16:0] FIXED_OFS  = 17'h10000;
  localparam logic [15:0] SNOOP_LO   = 16'h6000;
  localparam logic [15:0] SNOOP_HI   = 16'h7FFF;
  localparam logic [1:0]  BS_RESET   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/slapstik_addr_map.sv
// CPU address to ROM word address decode; also reused by the debug ROM-patch path.
module slapstik_addr_map
  import slapstik_pkg::*;
(
  input  logic [15:0] cpu_ad,
  input  logic [1:0]  bs,
  output logic        claimed,
  output logic        snoop,
  output logic [15:0] word_addr,
  output logic        byte_sel
);

  assign claimed  = (cpu_ad >= BANK_BASE);
  assign snoop    = (cpu_ad >= SNOOP_LO) && (cpu_ad <= SNOOP_HI);
  assign byte_sel = cpu_ad[0];

  // Banked window is {bs, ad[13:0]}; fixed window sits at FIXED_OFS in the image.
  always_comb begin
    if (cpu_ad >= FIXED_BASE) word_addr = FIXED_OFS[16:1] + {2'b00, cpu_ad[14:1]};
    else                      word_addr = {1'b0, bs, cpu_ad[13:1]};
  end

endmodule

// File: rtl/slapstik_rom_fetch.sv
// ROM fetch front end for 6502 reads of 0x4000-0xFFFF with slapstik snoop strobe.
// Optional one-word cache: define SLAPSTIK_ROM_CACHE_EN.
module slapstik_rom_fetch
  import slapstik_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CPU_REQ,
  input  logic [15:0] CPU_AD,
  output logic        CPU_RDY,
  output logic [7:0]  CPU_DOUT,
  output logic        CPU_DVALID,
  input  logic [1:0]  BS,
  output logic        SS_CS,
  output logic [12:0] SS_AD,
  output logic        ROM_REQ,
  output logic [15:0] ROM_ADDR,
  input  logic        ROM_ACK,
  input  logic [15:0] ROM_DQ,
  output state_t      DBG_STATE
);

  // Handshake: a CPU_REQ is taken only while CPU_RDY is high and the address is
  // claimed; ROM_REQ is a level held until the single-cycle ROM_ACK in FETCH.
  state_t      state;
  logic        claimed, snoop, byte_sel, hit, accept, hi_q;
  logic [15:0] word_addr, word_q;

  slapstik_addr_map u_addr_map (
    .cpu_ad    (CPU_AD),
    .bs        (BS),
    .claimed   (claimed),
    .snoop     (snoop),
    .word_addr (word_addr),
    .byte_sel  (byte_sel)
  );

`ifdef SLAPSTIK_ROM_CACHE_EN
  logic [15:0] tag_q;
  logic        valid_q;
  assign hit = valid_q && (tag_q == word_addr);
`else
  assign hit = 1'b0;
`endif

  assign accept    = (state == ST_IDLE) && CPU_REQ && claimed;
  assign DBG_STATE = state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      CPU_RDY    <= 1'b1;
      CPU_DOUT   <= 8'hFF;
      CPU_DVALID <= 1'b0;
      SS_CS      <= 1'b0;
      SS_AD      <= '0;
      ROM_REQ    <= 1'b0;
      ROM_ADDR   <= '0;
      word_q     <= '0;
      hi_q       <= 1'b0;
`ifdef SLAPSTIK_ROM_CACHE_EN
      tag_q      <= '0;
      valid_q    <= 1'b0;
`endif
    end else begin
      CPU_DVALID <= 1'b0;
      SS_CS      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            hi_q    <= byte_sel;
            CPU_RDY <= 1'b0;
            if (snoop) begin
              SS_CS <= 1'b1;
              SS_AD <= CPU_AD[12:0];
            end
            if (hit) begin
              state <= ST_DONE;
            end else begin
              ROM_REQ  <= 1'b1;
              ROM_ADDR <= word_addr;
              state    <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (ROM_ACK) begin
            word_q  <= ROM_DQ;
            ROM_REQ <= 1'b0;
            state   <= ST_DONE;
`ifdef SLAPSTIK_ROM_CACHE_EN
            tag_q   <= ROM_ADDR;
            valid_q <= 1'b1;
`endif
          end
        end
        ST_DONE: begin
          CPU_DVALID <= 1'b1;
          CPU_DOUT   <= sel_byte(word_q, hi_q);
          CPU_RDY    <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/slapstik_rom_fetch.md
Name: slapstik_rom_fetch

Overview:
- Sits between the 6502 bus decoder and the program ROM store (SDRAM-style word port).
- Maps CPU reads of 0x4000-0xFFFF onto the 64KB-plus ROM image. The 0x4000-0x7FFF window is banked by the slapstik bank select BS.
- Generates the one-cycle CS/AD snoop strobe that drives the slapstik state machine.
- Holds the CPU with a ready signal while a ROM word fetch is outstanding.

Parameters:
- BANK_BASE, 16'h4000, start of the 16KB banked window; 0x6000-0x7FFF is also the slapstik snoop range.
- FIXED_OFS, 17'h10000, ROM byte offset of the fixed 0x8000-0xFFFF window.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CPU_REQ  in  1  one-cycle read request; CPU_AD valid with it
- CPU_AD  in  16  CPU byte address
- CPU_RDY  out  1  high = block can accept CPU_REQ
- CPU_DOUT  out  8  read data
- CPU_DVALID  out  1  one-cycle pulse, CPU_DOUT valid
- BS  in  2  current slapstik bank select
- SS_CS  out  1  one-cycle slapstik snoop strobe
- SS_AD  out  13  slapstik snoop address (CPU_AD[12:0])
- ROM_REQ  out  1  ROM word request, level, held until ack
- ROM_ADDR  out  16  ROM word address (byte address [16:1])
- ROM_ACK  in  1  one-cycle ack; ROM_DQ valid with it
- ROM_DQ  in  16  ROM word data

Behaviour:
- Reset (async, RST_N low):
  - Outputs: ROM_REQ=0, CPU_RDY=1, CPU_DVALID=0, SS_CS=0, SS_AD=0, CPU_DOUT=8'hFF, ROM_ADDR=0.
  - Internals: cache invalid; state IDLE. Reset mid-fetch drops ROM_REQ immediately; a late ROM_ACK is ignored.
- Address map:
  - CPU_AD in 0x4000-0x7FFF: byte address = {BS_latched, CPU_AD[13:0]}.
  - CPU_AD in 0x8000-0xFFFF: byte address = FIXED_OFS + CPU_AD[14:0].
  - CPU_AD < 0x4000: not claimed. No strobe, no fetch, no DVALID, CPU_RDY unchanged.
- BS is sampled on the CPU_REQ cycle. A bank change caused by the same access applies only to later accesses.
- SS_CS pulses for exactly one cycle, the cycle after any claimed CPU_REQ with CPU_AD in 0x6000-0x7FFF. SS_AD is registered from CPU_AD[12:0] on the same edge and held until the next strobe.
- Byte select: CPU_AD[0]=0 gives word[7:0]; CPU_AD[0]=1 gives word[15:8].
- State machine:
  - IDLE: CPU_RDY=1. On a claimed CPU_REQ, latch the word address and byte select.
    - Cache hit: go to DONE.
    - Miss: set ROM_REQ=1 and ROM_ADDR, go to FETCH.
  - FETCH: CPU_RDY=0; ROM_REQ held. On ROM_ACK, store ROM_DQ into the cache (tag = word address, valid=1), drop ROM_REQ, go to DONE.
  - DONE: CPU_DVALID=1 for one cycle, CPU_DOUT = selected byte. Return to IDLE with CPU_RDY=1 the next cycle.
- Latency, CPU_REQ to CPU_DVALID:
  - Hit: 2 cycles.
  - Miss: ROM_REQ rises 1 cycle after CPU_REQ; DVALID comes 2 cycles after the ROM_ACK edge.
- Boundary cases:
  - CPU_REQ while CPU_RDY=0 is ignored; no strobe is generated.
  - ROM_ACK outside FETCH is ignored.
  - CPU_DOUT holds its last value between pulses.
  - A new cache fill replaces the single entry.

Optional Feature:
- SLAPSTIK_ROM_CACHE_EN defined: one-word cache as above.
- Not defined: no cache; every claimed read takes the FETCH path. Tag/valid registers are absent.

Decomposition:
- Shared package (slapstik_pkg):
  - Window constants (BANK_BASE, FIXED_OFS, snoop range 0x6000/0x7FFF).
  - State encoding (IDLE/FETCH/DONE).
  - Bank-select reset value 2'd3.
- One natural sub-module: slapstik_addr_map. Combinational: CPU_AD plus BS to claimed/snoop/word address/byte select. It is shared with the debug ROM-patch path.

Test Plan:
- Reset with BS=3, read 0x4001 -> SS_CS=0; ROM_REQ rises 1 cycle later with ROM_ADDR=16'h6000; ack with ROM_DQ=16'hA55A -> CPU_DOUT=8'hA5, one DVALID pulse.
- Read 0x6000 -> SS_CS pulse with SS_AD=0; then read 0x6080 -> SS_AD=13'h0080; then change BS to 0, read 0x4000 -> ROM_ADDR=16'h0000.
- Read 0x8002 -> ROM_ADDR=16'h8001; read 0x8003 with cache enabled -> no ROM_REQ, DVALID 2 cycles after CPU_REQ, byte [15:8].
- Read 0x8002 -> ROM_REQ=1, ack delayed 10 cycles; CPU_REQ issued mid-wait -> ignored, no SS_CS, a single DVALID only.
- RST_N low during FETCH -> ROM_REQ=0 asynchronously. Ack after reset release -> no DVALID. Next read of the same address misses (cache invalid).
- Read 0x3FFF -> no SS_CS, no ROM_REQ, no DVALID, CPU_RDY stays 1.
